// File: rtl/prbs7_checker.sv
// Receive-side PRBS-7 (x^7+x^6+1) checker: self-seeds a local predictor from the
// incoming stream, verifies it, then counts checked bits and errors while locked.
module prbs7_checker #(
    parameter int CNT_W     = 32,
    parameter int LOCK_BITS = 32,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W  = (LOCK_BITS > 1) ? $clog2(LOCK_BITS) : 1;
    localparam int WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_MAX = (LOSS_ERRS > WINDOW) ? LOSS_ERRS : WINDOW;
    localparam int WERR_W   = $clog2(WERR_MAX + 1);

    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_BITS - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  LOSS_LIM  = WERR_W'(LOSS_ERRS);

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    state_t             state, stateNext;
    logic [6:0]         sr, srNext;
    logic [2:0]         seedCnt, seedCntNext;
    logic [MATCH_W-1:0] matchCnt, matchCntNext;
    logic [WIN_W-1:0]   winCnt, winCntNext;
    logic [WERR_W-1:0]  winErr, winErrNext, winErrSum;
    logic [CNT_W-1:0]   bitCountNext, errCountNext;
    logic               errPulseNext;
    logic               expBit;
    logic               mismatch;

    assign expBit   = sr[6] ^ sr[5];
    assign mismatch = rx_bit ^ expBit;
    assign locked   = (state == LOCKED);

    always_comb begin
        stateNext    = state;
        srNext       = sr;
        seedCntNext  = seedCnt;
        matchCntNext = matchCnt;
        winCntNext   = winCnt;
        winErrNext   = winErr;
        bitCountNext = bit_count;
        errCountNext = err_count;
        errPulseNext = 1'b0;
        winErrSum    = winErr + WERR_W'(mismatch);

        if (rx_valid) begin
            case (state)
                SEED: begin
                    srNext = {sr[5:0], rx_bit};
                    if (seedCnt == 3'd6) begin
                        seedCntNext = 3'd0;
                        // An all-zero seed would predict zeros forever, so keep seeding.
                        if ({sr[5:0], rx_bit} != 7'd0) begin
                            stateNext    = VERIFY;
                            matchCntNext = '0;
                        end
                    end else begin
                        seedCntNext = seedCnt + 3'd1;
                    end
                end
                VERIFY: begin
                    srNext = {sr[5:0], rx_bit};
                    if (mismatch) begin
                        stateNext   = SEED;
                        seedCntNext = 3'd0;
                    end else if (matchCnt == LOCK_LAST) begin
                        stateNext    = LOCKED;
                        matchCntNext = '0;
                        winCntNext   = '0;
                        winErrNext   = '0;
                    end else begin
                        matchCntNext = matchCnt + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so isolated bit errors do not corrupt it.
                    srNext = {sr[5:0], expBit};
                    if (bit_count != '1) bitCountNext = bit_count + CNT_W'(1);
                    if (mismatch) begin
                        errPulseNext = 1'b1;
                        if (err_count != '1) errCountNext = err_count + CNT_W'(1);
                    end
                    if (winCnt == WIN_LAST) begin
                        winCntNext = '0;
                        winErrNext = '0;
                        if (winErrSum >= LOSS_LIM) begin
                            stateNext   = SEED;
                            seedCntNext = 3'd0;
                        end
                    end else begin
                        winCntNext = winCnt + WIN_W'(1);
                        winErrNext = winErrSum;
                    end
                end
                default: begin
                    stateNext   = SEED;
                    seedCntNext = 3'd0;
                end
            endcase
        end

        if (clear_counts) begin
            bitCountNext = '0;
            errCountNext = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SEED;
            sr        <= 7'd0;
            seedCnt   <= 3'd0;
            matchCnt  <= '0;
            winCnt    <= '0;
            winErr    <= '0;
            err_pulse <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            state     <= stateNext;
            sr        <= srNext;
            seedCnt   <= seedCntNext;
            matchCnt  <= matchCntNext;
            winCnt    <= winCntNext;
            winErr    <= winErrNext;
            err_pulse <= errPulseNext;
            bit_count <= bitCountNext;
            err_count <= errCountNext;
        end
    end

endmodule
